demosaicing_frame_ctrl: RTL
===========================

Name: demosaicing_frame_ctrl

Overview:
Frame-synchronous controller for the bilinear 3x3 demosaicing datapath. It holds the Bayer-pattern and enable settings written by the CSR block and applies them to the datapath only at start-of-frame, so the setting never changes mid-frame. It also monitors the raw AXI4-Stream handshake to track pixel, line and frame position, count frames and latch geometry errors for CSR readback. It sits between the CSR block and the demosaicing core and passively snoops the raw input stream.

Parameters:
FRAME_RES_X, 1920, expected pixels per line (tlast on beat FRAME_RES_X).
FRAME_RES_Y, 1080, expected lines per frame.
FRAME_CNT_WIDTH, 16, width of the frame counter.
TIMEOUT_CYCLES, 4096, stall limit used only when the optional feature is compiled in.

Ports:
clk_i  in  1  clock.
rst_n_i  in  1  synchronous reset, active-low.
cfg_pattern_i  in  2  Bayer order requested by CSR: 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.
cfg_en_i  in  1  requested demosaicing enable.
cfg_update_i  in  1  one-cycle pulse that stages cfg_pattern_i and cfg_en_i.
err_clr_i  in  1  one-cycle pulse that clears all sticky errors.
mon_tvalid_i  in  1  raw stream tvalid (snooped).
mon_tready_i  in  1  raw stream tready (snooped).
mon_tlast_i  in  1  raw stream tlast, marks end of line.
mon_tuser_i  in  1  raw stream tuser, marks start of frame.
pattern_o  out  2  active Bayer order driven to the datapath.
en_o  out  1  active enable driven to the datapath.
update_pending_o  out  1  a staged setting is waiting for the next SOF.
in_frame_o  out  1  FSM is in ACTIVE.
frame_cnt_o  out  FRAME_CNT_WIDTH  number of completed frames; wraps.
line_err_o  out  1  sticky: a line length was not FRAME_RES_X.
frame_err_o  out  1  sticky: a frame line count was not FRAME_RES_Y.
sof_err_o  out  1  sticky: SOF arrived mid-line.
timeout_err_o  out  1  sticky: stall timeout (optional feature).

Behaviour:
- Beat: a cycle with mon_tvalid_i && mon_tready_i. Non-beat cycles are ignored; all valid/last/user qualification uses beats only.
- Reset (rst_n_i=0 at a clock edge): pattern_o=0, en_o=0, update_pending_o=0, in_frame_o=0, frame_cnt_o=0, all error flags 0, state=IDLE, counters=0, staged setting=0. Reset overrides every other event, including reset in the middle of a frame.
- Staging: cfg_update_i loads the staged pattern and enable registers and sets pending. A second update while pending overwrites the staged values (last write wins).
- Apply: on a beat with tuser=1, if pending was set before that cycle, pattern_o and en_o take the staged values one cycle later, and pending clears. An update in the same cycle as an SOF beat is not applied to that frame; it stays pending for the next SOF.
- All outputs are registered: they reflect a beat 1 cycle after it.
- FSM IDLE -> ACTIVE on an SOF beat. Beats in IDLE that lack tuser are ignored.
- FSM ACTIVE: the pixel counter x increments on each beat and saturates at FRAME_RES_X+1.
  - On a tlast beat: if x+1 != FRAME_RES_X, set line_err. Then x=0 and line counter y increments.
  - If y reaches FRAME_RES_Y on a tlast beat: frame_cnt increments (wraps at 2^FRAME_CNT_WIDTH) and the FSM goes to GAP.
- FSM GAP: an SOF beat goes to ACTIVE with x=1, y=0. A non-SOF beat in GAP sets frame_err (extra line) and the FSM stays in GAP.
- SOF beat while ACTIVE: if x!=0, set sof_err. If y!=FRAME_RES_Y, set frame_err. The frame restarts (x=1, y=0), and the staged-setting apply rule is the same as above. frame_cnt is not incremented for a truncated frame.
- An SOF beat that also has tlast is treated as a 1-pixel line: SOF handling runs first, then tlast handling.
- x, y width: $clog2(FRAME_RES_X+2) and $clog2(FRAME_RES_Y+2).
- err_clr_i clears the sticky flags. If err_clr_i and a new error occur in the same cycle, the error wins.
- Reset value of en_o=0: the datapath is disabled until the first configured SOF.

Optional Feature:
DEMOSAICING_FRAME_CTRL_TIMEOUT_EN:
- Defined: a stall counter runs while in ACTIVE, resets on every beat, and clears on leaving ACTIVE. When it reaches TIMEOUT_CYCLES it sets timeout_err and the FSM goes to IDLE with x=y=0; the next SOF resynchronises.
- Not defined: no stall counter exists and timeout_err_o is tied to 0.

Test Plan:
- FRAME_RES_X=8, FRAME_RES_Y=4; drive 3 clean frames with random tready/tvalid gaps -> frame_cnt_o=3, all error flags 0, in_frame_o=0 in each inter-frame gap.
- Pulse cfg_update_i with pattern=2, en=1 mid-frame -> update_pending_o=1 and pattern_o/en_o unchanged until the next SOF beat, then pattern_o=2, en_o=1 one cycle later. Repeat with the update in the same cycle as SOF -> applied one frame later.
- Two updates (pattern=1, then 3) within one frame -> pattern_o=3 after the SOF.
- tlast on beat 7 of line 2 -> line_err_o=1. err_clr_i -> 0. err_clr_i in the same cycle as a new error -> stays 1.
- SOF after 2 lines plus 3 pixels -> sof_err_o=1, frame_err_o=1, frame_cnt_o unchanged. The next clean frame increments frame_cnt_o.
- With DEMOSAICING_FRAME_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, hold tvalid=0 mid-frame for 16 cycles -> timeout_err_o=1, in_frame_o=0. The next frame counts normally.

Source files
------------

// File: rtl/demosaicing_frame_ctrl_if.sv
// demosaicing_frame_ctrl_if
//   The raw AXI4-Stream handshake seen by the demosaicing core. The frame
//   controller only observes these signals and never drives them.
//   tvalid / tready : handshake; a beat is tvalid && tready
//   tlast           : end of line
//   tuser           : start of frame
//   master : the side that drives the stream (source/sink pair or a bench)
//   slave  : the passive observer (frame controller)
interface demosaicing_frame_ctrl_if;
  logic tvalid;
  logic tready;
  logic tlast;
  logic tuser;

  modport master (output tvalid, tready, tlast, tuser);
  modport slave  (input  tvalid, tready, tlast, tuser);
endinterface

// File: rtl/demosaicing_frame_ctrl.sv
// demosaicing_frame_ctrl
//   Frame-synchronous controller for the bilinear 3x3 demosaicing datapath.
//   Bayer pattern / enable written by CSR are staged and only handed to the
//   datapath on a start-of-frame beat. The raw stream is snooped to track
//   x/y position, count completed frames and latch sticky geometry errors.
//
//   Optional build macro: DEMOSAICING_FRAME_CTRL_TIMEOUT_EN adds a stall
//   counter that drops back to IDLE after TIMEOUT_CYCLES beat-less cycles
//   inside a frame. Without it timeout_err_o is constant 0.
//
//   Ports
//     clk_i, rst_n_i          clock, synchronous active-low reset
//     cfg_pattern_i/cfg_en_i  requested Bayer order / enable
//     cfg_update_i            stage the request (pulse)
//     err_clr_i               clear sticky errors (pulse)
//     mon                     snooped raw stream (slave modport)
//     pattern_o/en_o          active setting to the datapath
//     update_pending_o        staged setting awaiting SOF
//     in_frame_o              FSM in ACTIVE
//     frame_cnt_o             completed frames (wraps)
//     *_err_o                 sticky line / frame / sof / timeout errors
module demosaicing_frame_ctrl #(
  parameter int FRAME_RES_X     = 1920,
  parameter int FRAME_RES_Y     = 1080,
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [1:0]                 cfg_pattern_i,
  input  logic                       cfg_en_i,
  input  logic                       cfg_update_i,
  input  logic                       err_clr_i,
  demosaicing_frame_ctrl_if.slave    mon,
  output logic [1:0]                 pattern_o,
  output logic                       en_o,
  output logic                       update_pending_o,
  output logic                       in_frame_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o,
  output logic                       line_err_o,
  output logic                       frame_err_o,
  output logic                       sof_err_o,
  output logic                       timeout_err_o
);
  localparam int XW = $clog2(FRAME_RES_X + 2);
  localparam int YW = $clog2(FRAME_RES_Y + 2);
  localparam logic [XW-1:0] X_LINE = XW'(FRAME_RES_X);
  localparam logic [XW-1:0] X_MAX  = XW'(FRAME_RES_X + 1);
  localparam logic [YW-1:0] Y_FRAME = YW'(FRAME_RES_Y);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be positive");
  end

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t state, state_nxt;
  logic [XW-1:0] x, x_nxt, px, pcnt;
  logic [YW-1:0] y, y_nxt, py, y_inc;
  logic [FRAME_CNT_WIDTH-1:0] cnt_nxt;
  logic [1:0] stg_pat;
  logic stg_en;
  logic beat, sof, run;
  logic line_set, frame_set, sof_set;

  assign beat = mon.tvalid && mon.tready;
  assign sof  = beat && mon.tuser;

`ifdef DEMOSAICING_FRAME_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] stall;
  logic to_set;
`endif

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    cnt_nxt   = frame_cnt_o;
    line_set  = 1'b0;
    frame_set = 1'b0;
    sof_set   = 1'b0;
    run       = 1'b0;
    px        = x;
    py        = y;
    // An SOF beat restarts position from zero and is then counted as the
    // first pixel, so SOF+tlast naturally becomes a 1-pixel line.
    if (sof) begin
      if (state == ACTIVE) begin
        sof_set   = (x != '0);
        frame_set = (y != Y_FRAME);
      end
      state_nxt = ACTIVE;
      px        = '0;
      py        = '0;
      run       = 1'b1;
    end else if (beat) begin
      case (state)
        ACTIVE:  run = 1'b1;
        GAP:     frame_set = 1'b1;
        default: ;
      endcase
    end
    pcnt  = (px == X_MAX) ? px : px + XW'(1);
    y_inc = py + YW'(1);
    if (run) begin
      if (mon.tlast) begin
        line_set = (pcnt != X_LINE);
        x_nxt    = '0;
        y_nxt    = y_inc;
        if (y_inc == Y_FRAME) begin
          cnt_nxt   = frame_cnt_o + FRAME_CNT_WIDTH'(1);
          state_nxt = GAP;
        end
      end else begin
        x_nxt = pcnt;
        y_nxt = py;
      end
    end
`ifdef DEMOSAICING_FRAME_CTRL_TIMEOUT_EN
    to_set = 1'b0;
    if (state == ACTIVE && !beat && stall == TW'(TIMEOUT_CYCLES - 1)) begin
      to_set    = 1'b1;
      state_nxt = IDLE;
      x_nxt     = '0;
      y_nxt     = '0;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state            <= IDLE;
      x                <= '0;
      y                <= '0;
      frame_cnt_o      <= '0;
      in_frame_o       <= 1'b0;
      line_err_o       <= 1'b0;
      frame_err_o      <= 1'b0;
      sof_err_o        <= 1'b0;
      stg_pat          <= '0;
      stg_en           <= 1'b0;
      update_pending_o <= 1'b0;
      pattern_o        <= '0;
      en_o             <= 1'b0;
    end else begin
      state       <= state_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      frame_cnt_o <= cnt_nxt;
      in_frame_o  <= (state_nxt == ACTIVE);
      // A new error in the same cycle as a clear survives.
      line_err_o  <= (line_err_o  & ~err_clr_i) | line_set;
      frame_err_o <= (frame_err_o & ~err_clr_i) | frame_set;
      sof_err_o   <= (sof_err_o   & ~err_clr_i) | sof_set;
      // Apply uses the setting staged before this cycle; an update landing
      // on the SOF beat itself stays pending for the following frame.
      if (sof && update_pending_o) begin
        pattern_o <= stg_pat;
        en_o      <= stg_en;
      end
      if (cfg_update_i) begin
        stg_pat          <= cfg_pattern_i;
        stg_en           <= cfg_en_i;
        update_pending_o <= 1'b1;
      end else if (sof) begin
        update_pending_o <= 1'b0;
      end
    end
  end

`ifdef DEMOSAICING_FRAME_CTRL_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stall         <= '0;
      timeout_err_o <= 1'b0;
    end else begin
      if (state_nxt != ACTIVE || beat) stall <= '0;
      else                             stall <= stall + TW'(1);
      timeout_err_o <= (timeout_err_o & ~err_clr_i) | to_set;
    end
  end
`else
  assign timeout_err_o = 1'b0;
`endif
endmodule
